// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared FSM state type and funct3 size codes for the memory access unit
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } memstate_t;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - combinational byte-lane enables, store replication, load extraction and legality
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        ifetch,
  input  logic [1:0]  adr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext,
  output logic        legal
);

  logic [2:0]  size;
  logic [31:0] lane;

  // Fetches always behave as word loads regardless of funct3.
  assign size = ifetch ? MEM_W : funct3;
  assign lane = rdata >> {adr, 3'b000};

  always_comb begin
    legal     = 1'b0;
    be        = 4'b1111;
    wdata_al  = wdata;
    rdata_ext = rdata;
    case (size)
      MEM_B, MEM_BU: begin
        legal     = 1'b1;
        be        = 4'b0001 << adr;
        wdata_al  = {4{wdata[7:0]}};
        rdata_ext = (size == MEM_B) ? {{24{lane[7]}}, lane[7:0]} : {24'd0, lane[7:0]};
      end
      MEM_H, MEM_HU: begin
        legal     = ~adr[0];
        be        = 4'b0011 << {adr[1], 1'b0};
        wdata_al  = {2{wdata[15:0]}};
        rdata_ext = (size == MEM_H) ? {{16{lane[15]}}, lane[15:0]} : {16'd0, lane[15:0]};
      end
      MEM_W: begin
        legal = (adr == 2'b00);
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU memory port to valid/ready bus bridge; optional bus timeout under MEM_TIMEOUT_EN
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_ifetch,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_funct3,
  output logic [31:0] cpu_rdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  memstate_t   state, state_next;
  logic [1:0]  adr_lo_q;
  logic [2:0]  funct3_q;
  logic        ifetch_q;
  logic        err_q;
  logic        timeout;

  logic [1:0]  al_adr;
  logic [2:0]  al_funct3;
  logic        al_ifetch;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_legal;

  // The aligner sees the live request while idle and the latched one afterwards.
  assign al_adr    = (state == IDLE) ? cpu_adr[1:0] : adr_lo_q;
  assign al_funct3 = (state == IDLE) ? cpu_funct3   : funct3_q;
  assign al_ifetch = (state == IDLE) ? cpu_ifetch   : ifetch_q;

  mem_lane_align u_align (
    .funct3    (al_funct3),
    .ifetch    (al_ifetch),
    .adr       (al_adr),
    .wdata     (cpu_wdata),
    .rdata     (bus_rdata),
    .be        (al_be),
    .wdata_al  (al_wdata),
    .rdata_ext (al_rdata),
    .legal     (al_legal)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // Aborts on the cycle the count would reach TIMEOUT_CYCLES; a ready in that cycle still wins.
  assign timeout = ~bus_ready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset || state != ISSUE) begin
      wait_cnt <= '0;
    end else if (!bus_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cpu_busy   = (state != IDLE);
    bus_valid  = 1'b0;
    cpu_done   = 1'b0;
    cpu_err    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          state_next = al_legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        bus_valid = 1'b1;
        if (bus_ready || timeout) begin
          state_next = RESP;
        end
      end
      RESP: begin
        cpu_done   = 1'b1;
        cpu_err    = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      adr_lo_q  <= 2'b00;
      funct3_q  <= 3'b000;
      ifetch_q  <= 1'b0;
      err_q     <= 1'b0;
      cpu_rdata <= 32'd0;
      bus_we    <= 1'b0;
      bus_adr   <= 32'd0;
      bus_wdata <= 32'd0;
      bus_be    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            adr_lo_q <= cpu_adr[1:0];
            funct3_q <= cpu_funct3;
            ifetch_q <= cpu_ifetch;
            err_q    <= ~al_legal;
            if (al_legal) begin
              bus_we    <= cpu_we;
              bus_adr   <= {cpu_adr[31:2], 2'b00};
              bus_wdata <= al_wdata;
              bus_be    <= al_be;
            end
          end
        end
        ISSUE: begin
          if (bus_ready) begin
            if (!bus_we) begin
              cpu_rdata <= al_rdata;
            end
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ifetch;
  logic [31:0] cpu_adr, cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_rdata;
  logic        cpu_busy, cpu_done, cpu_err;
  logic        bus_valid, bus_we;
  logic [31:0] bus_adr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_rdata = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_ifetch (cpu_ifetch),
    .cpu_adr    (cpu_adr),
    .cpu_wdata  (cpu_wdata),
    .cpu_funct3 (cpu_funct3),
    .cpu_rdata  (cpu_rdata),
    .cpu_busy   (cpu_busy),
    .cpu_done   (cpu_done),
    .cpu_err    (cpu_err),
    .bus_valid  (bus_valid),
    .bus_we     (bus_we),
    .bus_adr    (bus_adr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: access size in bytes, lane offset, and extension from the size/sign rules.
  function automatic int nbytes(input logic ifetch, input logic [2:0] f3);
    if (ifetch) return 4;
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_legal(input logic ifetch, input logic [31:0] adr, input logic [2:0] f3);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return ifetch ? (adr % 4 == 0) : 1'b0;
    return (adr % nbytes(ifetch, f3)) == 0;
  endfunction

  task automatic access(input logic we, input logic ifetch, input logic [31:0] adr,
                        input logic [31:0] wd, input logic [2:0] f3, input logic [31:0] rd,
                        input int waits, input bit hold);
    int n, off;
    logic [63:0] mask, val;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    bit ok;
    n      = nbytes(ifetch, f3);
    off    = (adr % 4) / n * n;
    mask   = (64'd1 << (8 * n)) - 1;
    exp_be = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) exp_wd[i*8 +: 8] = wd[(i % n) * 8 +: 8];
    val = ({32'd0, rd} >> (8 * off)) & mask;
    if (!ifetch && !f3[2] && n < 4 && val[8*n-1]) val = val | ~mask;
    ok = is_legal(ifetch, adr, f3);

    cpu_we = we; cpu_ifetch = ifetch; cpu_adr = adr; cpu_wdata = wd; cpu_funct3 = f3;
    cpu_req = 1'b1;
    tick();
    if (!hold) cpu_req = 1'b0;
    if (ok) begin
      check("issue_valid", 32'(bus_valid), 32'd1);
      check("issue_busy", 32'(cpu_busy), 32'd1);
      check("issue_adr", bus_adr, {adr[31:2], 2'b00});
      check("issue_be", 32'(bus_be), 32'(exp_be));
      check("issue_we", 32'(bus_we), 32'(we));
      if (we) check("issue_wdata", bus_wdata, exp_wd);
      for (int i = 0; i < waits; i++) begin
        bus_ready = 1'b0;
        bus_rdata = $urandom;
        tick();
        check("wait_valid", 32'(bus_valid), 32'd1);
        check("wait_adr", bus_adr, {adr[31:2], 2'b00});
        check("wait_be", 32'(bus_be), 32'(exp_be));
        check("wait_done", 32'(cpu_done), 32'd0);
        if (we) check("wait_wdata", bus_wdata, exp_wd);
      end
      bus_ready = 1'b1;
      bus_rdata = rd;
      cpu_req   = 1'b0;
      tick();
      bus_ready = 1'b0;
      bus_rdata = $urandom;
      if (!we) model_rdata = val[31:0];
      check("resp_valid", 32'(bus_valid), 32'd0);
      check("resp_done", 32'(cpu_done), 32'd1);
      check("resp_err", 32'(cpu_err), 32'd0);
    end else begin
      cpu_req = 1'b0;
      check("illegal_valid", 32'(bus_valid), 32'd0);
      check("illegal_done", 32'(cpu_done), 32'd1);
      check("illegal_err", 32'(cpu_err), 32'd1);
    end
    check("resp_rdata", cpu_rdata, model_rdata);
    tick();
    check("idle_done", 32'(cpu_done), 32'd0);
    check("idle_busy", 32'(cpu_busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_ifetch = 1'b0;
    cpu_adr = 32'd0; cpu_wdata = 32'd0; cpu_funct3 = 3'd0;
    bus_ready = 1'b0; bus_rdata = 32'd0;
    repeat (3) tick();
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_busy", 32'(cpu_busy), 32'd0);
    check("rst_done", 32'(cpu_done), 32'd0);
    check("rst_err", 32'(cpu_err), 32'd0);
    check("rst_valid", 32'(bus_valid), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_adr", bus_adr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    reset = 1'b1;
    tick();

    // Ready while no request is outstanding must be ignored.
    bus_ready = 1'b1;
    repeat (2) tick();
    check("stray_ready_busy", 32'(cpu_busy), 32'd0);
    check("stray_ready_done", 32'(cpu_done), 32'd0);
    bus_ready = 1'b0;

    access(1'b0, 1'b1, 32'h100, 32'd0, 3'b011, 32'hDEADBEEF, 0, 1'b0);
    check("fetch_const", cpu_rdata, 32'hDEADBEEF);
    access(1'b0, 1'b0, 32'h203, 32'd0, 3'b000, 32'h80FFFFFF, 0, 1'b0);
    check("lb_const", cpu_rdata, 32'hFFFFFF80);
    access(1'b0, 1'b0, 32'h203, 32'd0, 3'b100, 32'h80FFFFFF, 1, 1'b0);
    check("lbu_const", cpu_rdata, 32'h00000080);
    access(1'b1, 1'b0, 32'h402, 32'h1234ABCD, 3'b001, 32'd0, 3, 1'b1);
    check("sh_rdata_kept", cpu_rdata, 32'h00000080);
    access(1'b0, 1'b0, 32'h006, 32'd0, 3'b010, 32'h55555555, 0, 1'b0);
    check("lw_mis_kept", cpu_rdata, 32'h00000080);
    access(1'b0, 1'b0, 32'h008, 32'd0, 3'b110, 32'h55555555, 0, 1'b0);

`ifdef MEM_TIMEOUT_EN
    cpu_we = 1'b0; cpu_ifetch = 1'b0; cpu_adr = 32'h40; cpu_funct3 = 3'b010;
    cpu_req = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("to_valid", 32'(bus_valid), 32'd1);
      tick();
    end
    check("to_valid_last", 32'(bus_valid), 32'd1);
    cpu_req = 1'b0;
    tick();
    check("to_drop", 32'(bus_valid), 32'd0);
    check("to_done", 32'(cpu_done), 32'd1);
    check("to_err", 32'(cpu_err), 32'd1);
    check("to_rdata", cpu_rdata, model_rdata);
    tick();
`endif

    // Reset in the middle of a bus wait.
    cpu_we = 1'b0; cpu_ifetch = 1'b0; cpu_adr = 32'h80; cpu_funct3 = 3'b010;
    cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    check("pre_rst_valid", 32'(bus_valid), 32'd1);
    reset = 1'b0;
    tick();
    model_rdata = 32'd0;
    check("midrst_valid", 32'(bus_valid), 32'd0);
    check("midrst_done", 32'(cpu_done), 32'd0);
    check("midrst_busy", 32'(cpu_busy), 32'd0);
    check("midrst_be", 32'(bus_be), 32'd0);
    check("midrst_adr", bus_adr, 32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_done", 32'(cpu_done), 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'hCAFEF00D, 3'b010, 32'd0, 1, 1'b0);

    for (int k = 0; k < 80; k++) begin
      logic [2:0] f3;
      logic ifc, w;
      f3  = 3'($urandom_range(0, 7));
      ifc = ($urandom_range(0, 5) == 0);
      w   = ifc ? 1'b0 : 1'($urandom);
      access(w, ifc, $urandom, $urandom, f3, $urandom, $urandom_range(0, 3), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
